// File: rtl/soc_boot_pkg.sv
// Shared types and constants for the SoC boot/reset sequencer.
package soc_boot_pkg;

  typedef enum logic [1:0] {HOLD, RUN, RESTART} boot_state_e;

  localparam int RESTART_COUNT_W    = 4;
  localparam int DEF_HOLD_CYCLES    = 127;
  localparam int DEF_RESTART_CYCLES = 16;
  localparam int DEF_WDT_CYCLES     = 1048576;

  function automatic logic [RESTART_COUNT_W-1:0] sat_inc(input logic [RESTART_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/soc_boot_controller_if.sv
// Restart/heartbeat handshake between the top-level wrapper and the boot sequencer.
interface soc_boot_controller_if;
  import soc_boot_pkg::*;

  logic                       RestartReq;
  logic                       Heartbeat;
  logic                       CoreReset;
  logic                       Running;
  logic                       RestartAck;
  logic                       WdtTrip;
  logic [RESTART_COUNT_W-1:0] RestartCount;

  modport master (
    output RestartReq, Heartbeat,
    input  CoreReset, Running, RestartAck, WdtTrip, RestartCount
  );

  modport slave (
    input  RestartReq, Heartbeat,
    output CoreReset, Running, RestartAck, WdtTrip, RestartCount
  );

endinterface

// File: rtl/soc_boot_watchdog.sv
// Heartbeat watchdog: any Heartbeat toggle restarts the timeout; expire is raised
// on the edge where the count would reach WDT_CYCLES-1 without a toggle.
module soc_boot_watchdog
  import soc_boot_pkg::*;
#(
  parameter int WDT_CYCLES = DEF_WDT_CYCLES
) (
  input  logic Clock,
  input  logic Reset,
  input  logic active,
  input  logic heartbeat,
  output logic expire
);

  localparam int             WW     = $clog2(WDT_CYCLES);
  localparam logic [WW-1:0]  EXP_AT = WW'(WDT_CYCLES - 2);

  logic          hb_q;
  logic [WW-1:0] cnt;
  logic          toggle;

  assign toggle = heartbeat ^ hb_q;
  // Comparing the pre-increment value keeps the trip on the same edge the count hits WDT_CYCLES-1.
  assign expire = active && !toggle && (cnt == EXP_AT);

  // hb_q tracks Heartbeat continuously, so it is freshly captured on the RUN entry edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hb_q <= 1'b0;
      cnt  <= '0;
    end else begin
      hb_q <= heartbeat;
      if (!active || toggle) cnt <= '0;
      else                   cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soc_boot_controller.sv
// Core reset sequencer: HOLD after board reset, RUN, timed RESTART on request.
// Optional heartbeat watchdog compiled in with SOC_BOOT_CTRL_WATCHDOG_EN.
module soc_boot_controller
  import soc_boot_pkg::*;
#(
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int RESTART_CYCLES = DEF_RESTART_CYCLES,
  parameter int WDT_CYCLES     = DEF_WDT_CYCLES
) (
  input  logic                 Clock,
  input  logic                 Reset,
  soc_boot_controller_if.slave bus
);

  localparam int             CNT_MAX  = (HOLD_CYCLES > RESTART_CYCLES) ? HOLD_CYCLES : RESTART_CYCLES;
  localparam int             CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0]  HOLD_END = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  RST_END  = CW'(RESTART_CYCLES - 1);

  boot_state_e                state;
  logic [CW-1:0]              cnt;
  logic                       core_rst_q, running_q, ack_q, trip_q;
  logic [RESTART_COUNT_W-1:0] rcount_q;
  logic                       in_run, wdt_expire, accept;

  assign in_run = (state == RUN);

`ifdef SOC_BOOT_CTRL_WATCHDOG_EN
  soc_boot_watchdog #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
    .Clock     (Clock),
    .Reset     (Reset),
    .active    (in_run),
    .heartbeat (bus.Heartbeat),
    .expire    (wdt_expire)
  );
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic unused_heartbeat;
  assign unused_heartbeat = bus.Heartbeat;
  assign wdt_expire       = 1'b0;
`endif

  // Request and watchdog expiry merge into a single trigger, so a coincidence counts once.
  assign accept = in_run && (bus.RestartReq || wdt_expire);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= HOLD;
      cnt        <= '0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      ack_q      <= 1'b0;
      trip_q     <= 1'b0;
      rcount_q   <= '0;
    end else begin
      ack_q  <= 1'b0;
      trip_q <= 1'b0;
      case (state)
        HOLD, RESTART: begin
          if (cnt == ((state == HOLD) ? HOLD_END : RST_END)) begin
            state      <= RUN;
            cnt        <= '0;
            core_rst_q <= 1'b0;
            running_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            state      <= RESTART;
            cnt        <= '0;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            ack_q      <= 1'b1;
            trip_q     <= wdt_expire;
            rcount_q   <= sat_inc(rcount_q);
          end
        end
        default: begin
          state      <= HOLD;
          cnt        <= '0;
          core_rst_q <= 1'b1;
          running_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CoreReset    = core_rst_q;
  assign bus.Running      = running_q;
  assign bus.RestartAck   = ack_q;
  assign bus.WdtTrip      = trip_q;
  assign bus.RestartCount = rcount_q;

endmodule

// File: doc/soc_boot_controller.md
# soc_boot_controller

Sequences the core reset for the TinyFPGA SoC top level. It holds the core (e.g. `Increment_TopLevel`) in reset for a fixed number of cycles after board reset, so BRAM initialisation settles before the core runs. It then releases the core and services restart requests, and optionally restarts the core from a heartbeat watchdog. It replaces ad-hoc reset counters in top-level wrappers.

## Interface
Parameters:
- `HOLD_CYCLES`, default 127: core-reset hold after board reset; must be ≥1.
- `RESTART_CYCLES`, default 16: core-reset hold on a restart; must be ≥1.
- `WDT_CYCLES`, default 1048576: heartbeat timeout, in cycles; must be ≥2; used only with the watchdog.

Ports:
- `Clock` in 1: system clock (16 MHz on BX).
- `Reset` in 1: asynchronous, active-high board reset.
- `RestartReq` in 1: level; sampled at each rising edge.
- `Heartbeat` in 1: core liveness bit (e.g. `Counter[18]`); any toggle counts as alive.
- `CoreReset` out 1: registered, active-high reset to the core.
- `Running` out 1: high while in `RUN`.
- `RestartAck` out 1: one-cycle pulse when a restart is accepted.
- `WdtTrip` out 1: one-cycle pulse when the watchdog causes a restart.
- `RestartCount` out 4: saturating count of accepted restarts.

## Operation
States:
- `HOLD`
  - Core in reset.
  - Cycle counter increments each edge.
  - When counter == `HOLD_CYCLES`-1, go to `RUN` and clear the counter.
- `RUN`
  - Core released.
  - On accepted restart, go to `RESTART`, clear the counter, and increment `RestartCount`, saturating at 15.
- `RESTART`
  - Core in reset.
  - When counter == `RESTART_CYCLES`-1, go to `RUN`.

Restart acceptance:
- A restart is accepted only in `RUN`.
- `RestartReq` high in `HOLD` or `RESTART` is ignored: no ack, not queued.
- `RestartReq` held high continuously re-triggers on each `RUN` entry. This is legal, and the bench checks it.

Watchdog (when compiled in):
- Previous `Heartbeat` is registered; a toggle clears the watchdog counter.
- Watchdog counter runs only in `RUN`. On `RUN` entry it is cleared and the `Heartbeat` sample is recaptured.
- Counter == `WDT_CYCLES`-1 with no toggle forms a restart trigger, identical to `RestartReq`, and also asserts `WdtTrip`.
- If `RestartReq` and watchdog expiry occur in the same cycle: one restart, one `RestartAck`, `WdtTrip` asserted, `RestartCount` +1 only.

Reset values:
- State `HOLD`, all counters 0.
- `CoreReset`=1, `Running`=0, `RestartAck`=0, `WdtTrip`=0, `RestartCount`=0.

Reset asserted mid-`RUN` or mid-`RESTART`:
- Immediate asynchronous return to reset values.
- A full `HOLD_CYCLES` hold follows deassertion.

## Timing
- Edge 1 is the first rising edge after `Reset` deasserts. `CoreReset` falls after edge `HOLD_CYCLES` (edge 127 at default). `Running` rises on the same edge.
- `RestartReq` high at edge N in `RUN`:
  - After edge N: `CoreReset`=1, `Running`=0, `RestartAck`=1 for exactly one cycle, `RestartCount` updated.
  - `CoreReset` falls after edge N+`RESTART_CYCLES`.
- Watchdog: with no toggle since `RUN` entry at edge E, expiry is evaluated at edge E+`WDT_CYCLES`-1. Response is identical to `RestartReq` at that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SOC_BOOT_CTRL_WATCHDOG_EN`.
- Defined: heartbeat edge detector and watchdog counter are present; `WdtTrip` behaves as above.
- Undefined: no watchdog logic; `Heartbeat` is unused; `WdtTrip` is tied 0; restarts come only from `RestartReq`.
- Ports are identical in both builds.

## Structure
- Package `soc_boot_pkg`: state enum (`HOLD`, `RUN`, `RESTART`), `RESTART_COUNT_W`=4, default cycle constants.
- Counter widths are derived with `$clog2` of the relevant parameter.
- Sub-module `soc_boot_watchdog`: edge detect, timeout counter, expiry pulse. It is instantiated only under `SOC_BOOT_CTRL_WATCHDOG_EN`.

## Test plan
- Release `Reset`, defaults → `CoreReset` high through edge 126, low after edge 127; `Running` rises at the same edge; no ack.
- One-cycle `RestartReq` at edge 200 → `RestartAck` one cycle; `CoreReset` high from edge 200 to edge 216; `RestartCount`=1.
- `RestartReq` pulsed during `HOLD` and during `RESTART` → no ack, count unchanged, hold lengths unaltered.
- 17 restarts → `RestartCount` saturates at 15.
- Watchdog build, `WDT_CYCLES`=1000, `Heartbeat` static → `WdtTrip` and `RestartAck` together 999 edges after `RUN` entry. With `Heartbeat` toggling every 500 cycles → no trip. With `RestartReq` coincident with expiry → single ack, count +1.
- `Reset` asserted mid-`RESTART` → outputs at reset values immediately; after release, a full 127-cycle hold; `RestartCount`=0.
